// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
//   Shared definitions for the hazard/forwarding unit:
//   - forward select encodings driven onto forwardA/forwardB
//   - register-zero index (never forwarded)
//   - bit layout of one shadow-pipeline entry:
//       [ENTRY_W-1]             valid
//       [SH_RD_LSB +: REG_W]    rd
//       [SH_WE_BIT]             we
//       [SH_LOAD_BIT]           is_load
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        NO_forward  = 2'b00,
        EX_forward  = 2'b01,
        MEM_forward = 2'b10,
        WB_forward  = 2'b11
    } fwd_sel_e;

    localparam int unsigned REG_ZERO    = 0;

    localparam int unsigned SH_LOAD_BIT = 0;
    localparam int unsigned SH_WE_BIT   = 1;
    localparam int unsigned SH_RD_LSB   = 2;
    localparam int unsigned SH_CTRL_W   = 3;   // valid + we + is_load

    // Total width of one shadow entry for a given register index width.
    function automatic int unsigned shadow_entry_w(input int unsigned reg_addr_w);
        return reg_addr_w + SH_CTRL_W;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select
//   Combinational priority encoder for one source operand. Compares the
//   operand index against the EX, MEM and WB shadow entries and picks the
//   youngest stage that will write it. Register zero never matches.
//
// Ports:
//   rs         in   REG_ADDR_W  source register index from ID
//   used       in   1           instruction actually reads rs
//   id_valid   in   1           ID holds a real instruction
//   ex_entry   in   ENTRY_W     shadow entry of the EX stage
//   mem_entry  in   ENTRY_W     shadow entry of the MEM stage
//   wb_entry   in   ENTRY_W     shadow entry of the WB stage
//   sel        out  2           NO/EX/MEM/WB forward select
//   load_hit   out  1           selected producer is a load still in EX or MEM
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter  int unsigned REG_ADDR_W = 5,
    localparam int unsigned ENTRY_W    = shadow_entry_w(REG_ADDR_W)
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic                  id_valid,
    input  logic [ENTRY_W-1:0]    ex_entry,
    input  logic [ENTRY_W-1:0]    mem_entry,
    input  logic [ENTRY_W-1:0]    wb_entry,
    output logic [1:0]            sel,
    output logic                  load_hit
);

    logic     ex_hit;
    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel_e;

    // A load that has reached WB forwards its loaded data like any other
    // writer, so the WB load flag plays no part in the decision.
    logic     unused_wb_load;
    assign unused_wb_load = wb_entry[SH_LOAD_BIT];

    function automatic logic stage_hit(
        input logic [ENTRY_W-1:0]    entry,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  src_used,
        input logic                  src_valid
    );
        logic [REG_ADDR_W-1:0] entry_rd;
        entry_rd = entry[SH_RD_LSB +: REG_ADDR_W];
        return entry[ENTRY_W-1] && entry[SH_WE_BIT]
            && (entry_rd != REG_ADDR_W'(REG_ZERO))
            && (entry_rd == src) && src_used && src_valid;
    endfunction

    assign ex_hit  = stage_hit(ex_entry,  rs, used, id_valid);
    assign mem_hit = stage_hit(mem_entry, rs, used, id_valid);
    assign wb_hit  = stage_hit(wb_entry,  rs, used, id_valid);

    // Youngest producer wins.
    always_comb begin
        sel_e    = NO_forward;
        load_hit = 1'b0;
        if (ex_hit) begin
            sel_e    = EX_forward;
            load_hit = ex_entry[SH_LOAD_BIT];
        end else if (mem_hit) begin
            sel_e    = MEM_forward;
            load_hit = mem_entry[SH_LOAD_BIT];
        end else if (wb_hit) begin
            sel_e    = WB_forward;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding selects and load-use hazard control for a 5-stage
//   pipeline. A private shadow pipeline of {valid, rd, we, is_load} tracks
//   the EX, MEM and WB occupants; all outputs are combinational from the ID
//   inputs and that shadow state.
//
// Optional build macro:
//   HAZARD_STAT_EN  enables the stall-cycle and forward-select counters;
//                   when undefined the stat ports are tied to zero.
//
// Ports:
//   clk          in   1           pipeline clock, rising edge
//   rst_n        in   1           synchronous active-low reset
//   id_valid     in   1           ID holds a real instruction
//   id_rs1       in   REG_ADDR_W  source register 1 index
//   id_rs2       in   REG_ADDR_W  source register 2 index
//   id_rs1_used  in   1           instruction reads rs1
//   id_rs2_used  in   1           instruction reads rs2
//   id_rd        in   REG_ADDR_W  destination index
//   id_we        in   1           instruction writes rd
//   id_is_load   in   1           instruction is a load
//   flush        in   1           ID instruction is wrong-path
//   forwardA     out  2           RD1 mux select
//   forwardB     out  2           RD2 mux select
//   stall        out  1           hold PC and IF/ID
//   bubble_ex    out  1           load a NOP into ID/EX
//   stat_stalls  out  STAT_W      stall cycle count
//   stat_fwds    out  STAT_W      non-NO forward select count
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  stall,
    output logic                  bubble_ex,
    output logic [STAT_W-1:0]     stat_stalls,
    output logic [STAT_W-1:0]     stat_fwds
);

    localparam int unsigned ENTRY_W = shadow_entry_w(REG_ADDR_W);

    logic [ENTRY_W-1:0] ex_q;
    logic [ENTRY_W-1:0] mem_q;
    logic [ENTRY_W-1:0] wb_q;
    logic [ENTRY_W-1:0] id_entry;
    logic               id_advance;
    logic               load_hit_a;
    logic               load_hit_b;

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .rs        (id_rs1),
        .used      (id_rs1_used),
        .id_valid  (id_valid),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (forwardA),
        .load_hit  (load_hit_a)
    );

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .rs        (id_rs2),
        .used      (id_rs2_used),
        .id_valid  (id_valid),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (forwardB),
        .load_hit  (load_hit_b)
    );

    // Flush beats stall: the wrong-path instruction is discarded, so there
    // is nothing to hold and fetch must be free to redirect.
    assign stall      = (load_hit_a | load_hit_b) & ~flush;
    assign bubble_ex  = stall | flush;

    assign id_advance = id_valid & ~stall & ~flush;
    assign id_entry   = {id_advance, id_rd, id_we, id_is_load};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= id_entry;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] fwd_cnt_q;
    logic [1:0]        fwd_inc;

    // Selects only count when ID actually issues this cycle.
    always_comb begin
        fwd_inc = '0;
        if (id_valid && !stall) begin
            fwd_inc = {1'b0, forwardA != NO_forward} + {1'b0, forwardB != NO_forward};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            end
            fwd_cnt_q <= fwd_cnt_q + STAT_W'(fwd_inc);
        end
    end

    assign stat_stalls = stall_cnt_q;
    assign stat_fwds   = fwd_cnt_q;
`else
    assign stat_stalls = '0;
    assign stat_fwds   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
`timescale 1ns/1ps
module tb_hazard_forward_unit;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STAT_W     = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  id_valid = 1'b0;
    logic [REG_ADDR_W-1:0] id_rs1 = '0;
    logic [REG_ADDR_W-1:0] id_rs2 = '0;
    logic                  id_rs1_used = 1'b0;
    logic                  id_rs2_used = 1'b0;
    logic [REG_ADDR_W-1:0] id_rd = '0;
    logic                  id_we = 1'b0;
    logic                  id_is_load = 1'b0;
    logic                  flush = 1'b0;
    logic [1:0]            forwardA;
    logic [1:0]            forwardB;
    logic                  stall;
    logic                  bubble_ex;
    logic [STAT_W-1:0]     stat_stalls;
    logic [STAT_W-1:0]     stat_fwds;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .stall       (stall),
        .bubble_ex   (bubble_ex),
        .stat_stalls (stat_stalls),
        .stat_fwds   (stat_fwds)
    );

    // Reference model: the last three instructions that entered EX,
    // youngest first (index 0 = EX, 1 = MEM, 2 = WB).
    typedef struct {
        bit          valid;
        int unsigned rd;
        bit          we;
        bit          ld;
    } instr_t;

    typedef struct {
        int unsigned       cyc;
        logic [1:0]        fa;
        logic [1:0]        fb;
        logic              st;
        logic              bb;
        logic [STAT_W-1:0] ss;
        logic [STAT_W-1:0] sf;
    } exp_t;

    instr_t            pipe[$];
    exp_t              exp_q[$];
    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;
    int unsigned       cyc      = 0;
    logic [STAT_W-1:0] m_stalls = '0;
    logic [STAT_W-1:0] m_fwds   = '0;

    function automatic void model_clear();
        instr_t empty;
        empty = '{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(empty);
    endfunction

    // Source selection: the youngest in-flight writer of rs wins; sel is
    // 1 + its age. Loads younger than WB cannot supply data yet.
    function automatic void ref_src(input int unsigned rs, input bit used, input bit v,
                                    output int unsigned sel, output bit load_hit);
        bit found;
        sel = 0;
        load_hit = 1'b0;
        found = 1'b0;
        if (v && used && rs != 0) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!found && pipe[i].valid && pipe[i].we && pipe[i].rd == rs) begin
                    found    = 1'b1;
                    sel      = i + 1;
                    load_hit = pipe[i].ld && (i < 2);
                end
            end
        end
    endfunction

    task automatic check(input string name, input int unsigned c,
                         input logic [STAT_W-1:0] act, input logic [STAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // One ID cycle: drive inputs, push the expected response, advance model.
    task automatic step(input bit v, input int unsigned rs1, input bit u1,
                        input int unsigned rs2, input bit u2, input int unsigned rd,
                        input bit we, input bit ld, input bit fl, input bit rst,
                        output bit st_pred);
        int unsigned sa, sb;
        bit          la, lb;
        exp_t        e;
        instr_t      n;
        @(posedge clk);
        #1;
        rst_n       = ~rst;
        id_valid    = v;
        id_rs1      = REG_ADDR_W'(rs1);
        id_rs2      = REG_ADDR_W'(rs2);
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = REG_ADDR_W'(rd);
        id_we       = we;
        id_is_load  = ld;
        flush       = fl;

        ref_src(rs1, u1, v, sa, la);
        ref_src(rs2, u2, v, sb, lb);
        st_pred = (la || lb) && !fl;

        e.cyc = cyc;
        e.fa  = sa[1:0];
        e.fb  = sb[1:0];
        e.st  = st_pred;
        e.bb  = st_pred || fl;
        e.ss  = m_stalls;
        e.sf  = m_fwds;
        exp_q.push_back(e);

        if (rst) begin
            model_clear();
            m_stalls = '0;
            m_fwds   = '0;
        end else begin
`ifdef HAZARD_STAT_EN
            if (st_pred) m_stalls = m_stalls + 1;
            if (v && !st_pred) m_fwds = m_fwds + STAT_W'(int'(sa != 0) + int'(sb != 0));
`endif
            n = '{valid: v && !st_pred && !fl, rd: rd, we: we, ld: ld};
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        cyc++;
    endtask

    // Issue one instruction, holding it in ID while a stall is predicted.
    task automatic issue(input int unsigned rd, input bit we, input bit ld,
                         input int unsigned rs1, input bit u1,
                         input int unsigned rs2, input bit u2);
        bit          st;
        int unsigned tries;
        tries = 0;
        do begin
            step(1'b1, rs1, u1, rs2, u2, rd, we, ld, 1'b0, 1'b0, st);
            tries++;
        end while (st && tries < 4);
    endtask

    task automatic nop();
        issue(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compare against the scoreboard on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("forwardA",    e.cyc, STAT_W'(forwardA),  STAT_W'(e.fa));
                check("forwardB",    e.cyc, STAT_W'(forwardB),  STAT_W'(e.fb));
                check("stall",       e.cyc, STAT_W'(stall),     STAT_W'(e.st));
                check("bubble_ex",   e.cyc, STAT_W'(bubble_ex), STAT_W'(e.bb));
                check("stat_stalls", e.cyc, stat_stalls,        e.ss);
                check("stat_fwds",   e.cyc, stat_fwds,          e.sf);
            end
        end
    end

    initial begin
        bit          st;
        bit          v, u1, u2, we, ld, fl, rst;
        int unsigned rs1, rs2, rd;

        model_clear();
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1, st);

        // add x5 ; sub x6,x5,x1  -> EX forward on A
        issue(5, 1'b1, 1'b0, 1, 1'b1, 2, 1'b1);
        issue(6, 1'b1, 1'b0, 5, 1'b1, 1, 1'b1);

        // add x5 ; 1/2/3 nops ; or x7,x1,x5  -> MEM / WB / NO on B
        for (int unsigned gap = 1; gap <= 3; gap++) begin
            issue(5, 1'b1, 1'b0, 1, 1'b1, 2, 1'b1);
            for (int unsigned k = 0; k < gap; k++) nop();
            issue(7, 1'b1, 1'b0, 1, 1'b1, 5, 1'b1);
        end
        repeat (3) nop();

        // lw x5 ; add x6,x5,x5  -> two stall cycles then WB forward on both
        issue(5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
        issue(6, 1'b1, 1'b0, 5, 1'b1, 5, 1'b1);
        repeat (3) nop();

        // add x0 ; use x0  -> never forwarded
        issue(0, 1'b1, 1'b0, 1, 1'b1, 2, 1'b1);
        issue(8, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1);

        // addi x5 ; addi x5 ; use x5  -> youngest (EX) wins
        issue(5, 1'b1, 1'b0, 1, 1'b1, 0, 1'b0);
        issue(5, 1'b1, 1'b0, 2, 1'b1, 0, 1'b0);
        issue(9, 1'b1, 1'b0, 5, 1'b1, 5, 1'b1);
        repeat (3) nop();

        // Load-use together with flush -> flush wins, EX gets a bubble
        issue(5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
        step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0, st);
        issue(10, 1'b1, 1'b0, 6, 1'b1, 5, 1'b1);
        repeat (3) nop();

        // Reset in the middle of a load-use stall
        issue(5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
        step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, st);
        step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1, st);
        step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, st);
        repeat (3) nop();

        // Randomized traffic over a small register set to provoke hazards
        st = 1'b0;
        {v, u1, u2, we, ld} = '0;
        {rs1, rs2, rd} = '0;
        for (int unsigned k = 0; k < 600; k++) begin
            if (!st) begin
                v   = ($urandom_range(0, 9) != 0);
                rs1 = $urandom_range(0, 3);
                rs2 = $urandom_range(0, 3);
                u1  = ($urandom_range(0, 4) != 0);
                u2  = ($urandom_range(0, 4) != 0);
                rd  = $urandom_range(0, 3);
                we  = ($urandom_range(0, 3) != 0);
                ld  = ($urandom_range(0, 9) < 3);
            end
            fl  = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 199) == 0);
            step(v, rs1, u1, rs2, u2, rd, we, ld, fl, rst, st);
            if (rst) st = 1'b0;
        end

        for (int unsigned i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Produces the 2-bit `forwardA`/`forwardB` selects consumed by the operand forwarding muxes in ID.
- Also produces load-use stall and bubble controls for the 5-stage pipeline.
- Keeps its own shadow pipeline of {valid, rd, we, is_load} for the EX, MEM and WB stages, advanced each clock.
- Selects are combinational from ID inputs and shadow state; stall and bubble follow the same timing.

Parameters:
- REG_ADDR_W, 5, register index width.
- STAT_W, 32, width of statistics counters (used only with HAZARD_STAT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 index.
- id_rs2  in  REG_ADDR_W  source register 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination index.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch/jump resolved; the ID instruction is wrong-path.
- forwardA  out  2  select for the RD1 mux: `NO_forward`/`EX_forward`/`MEM_forward`/`WB_forward`.
- forwardB  out  2  select for the RD2 mux, same encoding.
- stall  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX this cycle.
- stat_stalls  out  STAT_W  count of stall cycles (macro only).
- stat_fwds  out  STAT_W  count of non-NO forward selects (macro only).

Behaviour:
- Reset (rst_n=0 at posedge clk): all shadow valid bits = 0, rd = 0. Outputs: forwardA = forwardB = `NO_forward`, stall = 0, bubble_ex = 0, stat counters = 0.
- Shadow pipeline, every posedge when rst_n=1:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← ID entry, where the ID entry is {id_valid & ~stall & ~flush, id_rd, id_we, id_is_load}.
  - When stall or flush is high, EX receives an invalid entry (the bubble).
- Match definition: stage S matches rsX iff S.valid & S.we & (S.rd != 0) & (S.rd == id_rsX) & id_rsX_used & id_valid.
- Forward priority (youngest wins): EX → `EX_forward`, else MEM → `MEM_forward`, else WB → `WB_forward`, else `NO_forward`. Register 0 is never forwarded.
- Load-use stall: stall = 1 iff a matching stage is EX with is_load, or MEM with is_load (the forward path carries only ALU results).
  - Load in EX gives 2 stall cycles; load in MEM gives 1.
  - While stalled, forwardA/B are still driven but ignored.
- bubble_ex = stall | flush.
- Flush vs stall in the same cycle: flush wins. stall is forced to 0 so fetch redirects; the ID entry becomes a bubble.
- Back-to-back writers of the same rd: the youngest stage wins per the priority above.
- Reset mid-stall: stall drops at the next posedge with rst_n=0; shadow is cleared, so no stale forwarding occurs.
- No other latency: selects change in the same cycle ID inputs change.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- Defined:
  - stat_stalls increments on every posedge with stall=1.
  - stat_fwds increments by 1 for each of forwardA/forwardB that is non-NO while id_valid & ~stall, i.e. 0, 1 or 2 per cycle.
  - Counters wrap at 2^STAT_W and clear on reset.
- Undefined: both ports are tied to 0 and the counters are not synthesized.

Decomposition:
- Shared package (param.v): forward select encodings `NO_forward`=2'b00, `EX_forward`=2'b01, `MEM_forward`=2'b10, `WB_forward`=2'b11; register-zero constant; shadow entry field widths.
- One sub-module, fwd_select: a purely combinational priority encoder for one operand (rs, used, three stage entries → 2-bit select plus load-hit flag), instantiated twice.

Test Plan:
- `add x5` then `sub x6,x5,x1` back-to-back → forwardA=`EX_forward`, stall=0.
- `add x5`, nop, `or x7,x1,x5` → forwardB=`MEM_forward`; with two nops → `WB_forward`; with three nops → `NO_forward`.
- `lw x5` then `add x6,x5,x5` → stall=1 and bubble_ex=1 for 2 cycles, then forwardA=forwardB=`WB_forward`.
- `add x0,...` then use of x0 → `NO_forward`, stall=0.
- `addi x5` (in MEM) and `addi x5` (in EX) both writing x5 → `EX_forward`.
- Load-use stall asserted with flush=1 the same cycle → stall=0, bubble_ex=1, EX shadow invalid next cycle.
- rst_n=0 during a stall → next cycle stall=0 and all selects `NO_forward`.
- With HAZARD_STAT_EN: the load-use sequence above → stat_stalls=2.
